// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, combinational
// fetch-stage lookup, EX-stage resolution/redirect and branch/mispredict counters.
module branch_predictor #(
  parameter int DEPTH     = 64,
  parameter int TAG_WIDTH = 8,
  parameter int PC_WIDTH  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PC_WIDTH-1:0] i_pc_if,
  output logic                o_pred_taken,
  output logic [PC_WIDTH-1:0] o_pred_target,
  input  logic                i_upd_valid,
  input  logic [PC_WIDTH-1:0] i_upd_pc,
  input  logic                i_upd_is_br,
  input  logic                i_upd_is_jal,
  input  logic                i_upd_is_jalr,
  input  logic                i_upd_taken,
  input  logic [PC_WIDTH-1:0] i_upd_target,
  input  logic                i_upd_pred_taken,
  input  logic [PC_WIDTH-1:0] i_upd_pred_target,
  output logic                o_mispredict,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic [31:0]         o_cnt_branch,
  output logic [31:0]         o_cnt_mispred
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_WIDTH - 1;

  localparam logic [1:0] CTR_RESET     = 2'b01;
  localparam logic [1:0] CTR_BR_ALLOC  = 2'b10;
  localparam logic [1:0] CTR_JMP_ALLOC = 2'b11;

  // valid/ctr are control state and reset; tag/target/type are qualified by valid
  logic                 valid_q [DEPTH];
  logic [1:0]           ctr_q   [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q   [DEPTH];
  logic [PC_WIDTH-1:0]  tgt_q   [DEPTH];
  logic                 jmp_q   [DEPTH];
  logic [31:0]          cnt_branch_q;
  logic [31:0]          cnt_mispred_q;

  function automatic logic [1:0] ctr_inc_sat(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec_sat(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [IDX_W-1:0]     if_idx;
  logic [TAG_WIDTH-1:0] if_tag;
  logic                 if_hit;

  assign if_idx = i_pc_if[TAG_LO-1:2];
  assign if_tag = i_pc_if[TAG_HI:TAG_LO];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign o_pred_taken  = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
  assign o_pred_target = o_pred_taken ? tgt_q[if_idx] : i_pc_if + PC_WIDTH'(4);

  logic [IDX_W-1:0]     upd_idx;
  logic [TAG_WIDTH-1:0] upd_tag;
  logic                 upd_hit;
  logic                 upd_is_jmp;
  logic                 upd_alloc;
  logic                 upd_tgt_wr;
  logic                 upd_ctr_wr;
  logic [1:0]           upd_ctr_nxt;

  assign upd_idx    = i_upd_pc[TAG_LO-1:2];
  assign upd_tag    = i_upd_pc[TAG_HI:TAG_LO];
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_is_jmp = i_upd_is_jal || i_upd_is_jalr;
  assign upd_alloc  = i_upd_valid && !upd_hit && i_upd_taken;
  assign upd_tgt_wr = i_upd_valid && i_upd_taken;
  assign upd_ctr_wr = upd_alloc || (i_upd_valid && upd_hit && i_upd_is_br);

  always_comb begin
    upd_ctr_nxt = ctr_q[upd_idx];
    if (upd_alloc)
      upd_ctr_nxt = upd_is_jmp ? CTR_JMP_ALLOC : CTR_BR_ALLOC;
    else if (i_upd_taken)
      upd_ctr_nxt = ctr_inc_sat(ctr_q[upd_idx]);
    else
      upd_ctr_nxt = ctr_dec_sat(ctr_q[upd_idx]);
  end

  assign o_mispredict  = i_upd_valid &&
                         ((i_upd_pred_taken != i_upd_taken) ||
                          (i_upd_taken && (i_upd_pred_target != i_upd_target)));
  assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + PC_WIDTH'(4);

  // control state: async reset wins over a same-cycle update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (upd_alloc)    valid_q[upd_idx] <= 1'b1;
      if (upd_ctr_wr)   ctr_q[upd_idx]   <= upd_ctr_nxt;
      if (i_upd_valid)  cnt_branch_q     <= cnt_branch_q + 32'd1;
      if (o_mispredict) cnt_mispred_q    <= cnt_mispred_q + 32'd1;
    end
  end

  // entry payload, no reset
  always_ff @(posedge i_clk) begin
    if (upd_tgt_wr && !i_rst) tgt_q[upd_idx] <= i_upd_target;
    if (upd_alloc && !i_rst) begin
      tag_q[upd_idx] <= upd_tag;
      jmp_q[upd_idx] <= upd_is_jmp;
    end
  end

  assign o_cnt_branch  = cnt_branch_q;
  assign o_cnt_mispred = cnt_mispred_q;

  // word-offset and high PC bits do not participate in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pc_if, i_upd_pc};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (DEPTH=4): allocation, counter saturation,
// target update, aliasing/eviction, no-bypass, counter wrap and async reset.
module tb_branch_predictor;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc_if;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_is_br, i_upd_is_jal, i_upd_is_jalr;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_cnt_branch, o_cnt_mispred;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  branch_predictor #(.DEPTH(4), .TAG_WIDTH(8), .PC_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc_if(i_pc_if),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
    .i_upd_is_br(i_upd_is_br), .i_upd_is_jal(i_upd_is_jal), .i_upd_is_jalr(i_upd_is_jalr),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_target(i_upd_pred_target),
    .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_cnt_branch(o_cnt_branch), .o_cnt_mispred(o_cnt_mispred)
  );

  // cls = {br, jal, jalr}
  task automatic drive_upd(input logic [2:0] cls, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    i_upd_valid = 1'b1;
    {i_upd_is_br, i_upd_is_jal, i_upd_is_jalr} = cls;
    i_upd_pc = pc;
    i_upd_taken = tk;
    i_upd_target = tgt;
    i_upd_pred_taken = pt;
    i_upd_pred_target = ptgt;
  endtask

  task automatic idle_upd();
    i_upd_valid = 1'b0;
    {i_upd_is_br, i_upd_is_jal, i_upd_is_jalr} = 3'b000;
    i_upd_pc = '0;
    i_upd_taken = 1'b0;
    i_upd_target = '0;
    i_upd_pred_taken = 1'b0;
    i_upd_pred_target = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_pc_if = 32'h100;
    idle_upd();
    #1 i_rst = 1'b1;
    #2;
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL rst_pred_taken: got %0b want 0", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h104) begin n_bad++; $display("FAIL rst_pred_target: got %h want 00000104", o_pred_target); end
    n_vec++; if (o_cnt_branch !== 32'd0) begin n_bad++; $display("FAIL rst_cnt_branch: got %0d want 0", o_cnt_branch); end
    n_vec++; if (o_cnt_mispred !== 32'd0) begin n_bad++; $display("FAIL rst_cnt_mispred: got %0d want 0", o_cnt_mispred); end
    @(negedge i_clk) i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_br_alloc();
    drive_upd(3'b100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    i_pc_if = 32'h100;
    #1;
    n_vec++; if (o_mispredict !== 1'b1) begin n_bad++; $display("FAIL alloc_mispredict: got %0b want 1", o_mispredict); end
    n_vec++; if (o_redirect_pc !== 32'h80) begin n_bad++; $display("FAIL alloc_redirect: got %h want 00000080", o_redirect_pc); end
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL alloc_no_bypass: got %0b want 0", o_pred_taken); end
    tick();
    idle_upd();
    #1;
    n_vec++; if (o_pred_taken !== 1'b1) begin n_bad++; $display("FAIL alloc_pred_taken: got %0b want 1", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h80) begin n_bad++; $display("FAIL alloc_pred_target: got %h want 00000080", o_pred_target); end
    n_vec++; if (o_cnt_mispred !== 32'd1) begin n_bad++; $display("FAIL alloc_cnt_mispred: got %0d want 1", o_cnt_mispred); end
    n_vec++; if (o_cnt_branch !== 32'd1) begin n_bad++; $display("FAIL alloc_cnt_branch: got %0d want 1", o_cnt_branch); end
  endtask

  // counter walks 10->01->00->00->01->10->11->11->10 for br pc 0x100
  task automatic test_br_counter();
    logic [7:0] tk_v, pt_v, mp_v, pred_v;
    logic [31:0] exp_rd, exp_tg;
    tk_v   = 8'b0111_1000;
    pt_v   = 8'b1110_0001;
    mp_v   = 8'b1001_1001;
    pred_v = 8'b1111_0000;
    i_pc_if = 32'h100;
    for (int i = 0; i < 8; i++) begin
      drive_upd(3'b100, 32'h100, tk_v[i], 32'h80, pt_v[i], 32'h80);
      #1;
      exp_rd = tk_v[i] ? 32'h80 : 32'h104;
      n_vec++; if (o_mispredict !== mp_v[i]) begin n_bad++; $display("FAIL ctr_mispredict[%0d]: got %0b want %0b", i, o_mispredict, mp_v[i]); end
      n_vec++; if (o_redirect_pc !== exp_rd) begin n_bad++; $display("FAIL ctr_redirect[%0d]: got %h want %h", i, o_redirect_pc, exp_rd); end
      tick();
      idle_upd();
      #1;
      exp_tg = pred_v[i] ? 32'h80 : 32'h104;
      n_vec++; if (o_pred_taken !== pred_v[i]) begin n_bad++; $display("FAIL ctr_pred_taken[%0d]: got %0b want %0b", i, o_pred_taken, pred_v[i]); end
      n_vec++; if (o_pred_target !== exp_tg) begin n_bad++; $display("FAIL ctr_pred_target[%0d]: got %h want %h", i, o_pred_target, exp_tg); end
    end
    n_vec++; if (o_cnt_branch !== 32'd9) begin n_bad++; $display("FAIL ctr_cnt_branch: got %0d want 9", o_cnt_branch); end
    n_vec++; if (o_cnt_mispred !== 32'd5) begin n_bad++; $display("FAIL ctr_cnt_mispred: got %0d want 5", o_cnt_mispred); end
  endtask

  task automatic test_jalr();
    drive_upd(3'b001, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    i_pc_if = 32'h200;
    #1;
    n_vec++; if (o_mispredict !== 1'b1) begin n_bad++; $display("FAIL jalr_alloc_mispredict: got %0b want 1", o_mispredict); end
    n_vec++; if (o_redirect_pc !== 32'h300) begin n_bad++; $display("FAIL jalr_alloc_redirect: got %h want 00000300", o_redirect_pc); end
    tick();
    idle_upd();
    #1;
    n_vec++; if (o_pred_taken !== 1'b1) begin n_bad++; $display("FAIL jalr_pred_taken: got %0b want 1", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h300) begin n_bad++; $display("FAIL jalr_pred_target: got %h want 00000300", o_pred_target); end
    i_pc_if = 32'h100;
    #1;
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL jalr_evict_taken: got %0b want 0", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h104) begin n_bad++; $display("FAIL jalr_evict_target: got %h want 00000104", o_pred_target); end
    drive_upd(3'b001, 32'h200, 1'b1, 32'h340, 1'b1, 32'h300);
    i_pc_if = 32'h200;
    #1;
    n_vec++; if (o_mispredict !== 1'b1) begin n_bad++; $display("FAIL jalr_tgt_mispredict: got %0b want 1", o_mispredict); end
    n_vec++; if (o_redirect_pc !== 32'h340) begin n_bad++; $display("FAIL jalr_tgt_redirect: got %h want 00000340", o_redirect_pc); end
    n_vec++; if (o_pred_target !== 32'h300) begin n_bad++; $display("FAIL jalr_old_target: got %h want 00000300", o_pred_target); end
    tick();
    idle_upd();
    #1;
    n_vec++; if (o_pred_target !== 32'h340) begin n_bad++; $display("FAIL jalr_new_target: got %h want 00000340", o_pred_target); end
  endtask

  task automatic test_alias();
    drive_upd(3'b010, 32'h10, 1'b1, 32'h1000, 1'b0, 32'h14);
    tick();
    idle_upd();
    i_pc_if = 32'h10;
    #1;
    n_vec++; if (o_pred_taken !== 1'b1) begin n_bad++; $display("FAIL alias_first_taken: got %0b want 1", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h1000) begin n_bad++; $display("FAIL alias_first_target: got %h want 00001000", o_pred_target); end
    drive_upd(3'b010, 32'h20, 1'b1, 32'h2000, 1'b0, 32'h24);
    #1;
    n_vec++; if (o_pred_target !== 32'h1000) begin n_bad++; $display("FAIL alias_no_bypass: got %h want 00001000", o_pred_target); end
    tick();
    idle_upd();
    #1;
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL alias_evicted_taken: got %0b want 0", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h14) begin n_bad++; $display("FAIL alias_evicted_target: got %h want 00000014", o_pred_target); end
    i_pc_if = 32'h20;
    #1;
    n_vec++; if (o_pred_target !== 32'h2000) begin n_bad++; $display("FAIL alias_second_target: got %h want 00002000", o_pred_target); end
  endtask

  task automatic test_no_write();
    drive_upd(3'b100, 32'h30, 1'b0, 32'h0, 1'b0, 32'h34);
    #1;
    n_vec++; if (o_mispredict !== 1'b0) begin n_bad++; $display("FAIL nt_miss_mispredict: got %0b want 0", o_mispredict); end
    n_vec++; if (o_redirect_pc !== 32'h34) begin n_bad++; $display("FAIL nt_miss_redirect: got %h want 00000034", o_redirect_pc); end
    tick();
    drive_upd(3'b100, 32'h20, 1'b1, 32'h999, 1'b0, 32'h0);
    i_upd_valid = 1'b0;
    i_pc_if = 32'h20;
    #1;
    n_vec++; if (o_mispredict !== 1'b0) begin n_bad++; $display("FAIL idle_mispredict: got %0b want 0", o_mispredict); end
    tick();
    idle_upd();
    #1;
    n_vec++; if (o_pred_target !== 32'h2000) begin n_bad++; $display("FAIL no_write_target: got %h want 00002000", o_pred_target); end
    i_pc_if = 32'h30;
    #1;
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL nt_miss_no_alloc: got %0b want 0", o_pred_taken); end
    n_vec++; if (o_cnt_branch !== 32'd14) begin n_bad++; $display("FAIL idle_cnt_branch: got %0d want 14", o_cnt_branch); end
    n_vec++; if (o_cnt_mispred !== 32'd9) begin n_bad++; $display("FAIL idle_cnt_mispred: got %0d want 9", o_cnt_mispred); end
  endtask

  task automatic test_wrap();
    @(negedge i_clk);
    dut.cnt_branch_q = 32'hFFFF_FFFF;
    dut.cnt_mispred_q = 32'hFFFF_FFFF;
    drive_upd(3'b010, 32'h40, 1'b1, 32'h500, 1'b0, 32'h44);
    #1;
    n_vec++; if (o_cnt_branch !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", o_cnt_branch); end
    tick();
    idle_upd();
    #1;
    n_vec++; if (o_cnt_branch !== 32'd0) begin n_bad++; $display("FAIL wrap_cnt_branch: got %h want 00000000", o_cnt_branch); end
    n_vec++; if (o_cnt_mispred !== 32'd0) begin n_bad++; $display("FAIL wrap_cnt_mispred: got %h want 00000000", o_cnt_mispred); end
  endtask

  task automatic test_reset_mid();
    i_pc_if = 32'h40;
    #1;
    n_vec++; if (o_pred_target !== 32'h500) begin n_bad++; $display("FAIL rmid_pre_target: got %h want 00000500", o_pred_target); end
    drive_upd(3'b010, 32'h54, 1'b1, 32'h600, 1'b0, 32'h58);
    tick();
    n_vec++; if (o_cnt_branch !== 32'd1) begin n_bad++; $display("FAIL rmid_pre_cnt: got %0d want 1", o_cnt_branch); end
    @(negedge i_clk) i_rst = 1'b1;
    #1;
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL rmid_pred_taken: got %0b want 0", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h44) begin n_bad++; $display("FAIL rmid_pred_target: got %h want 00000044", o_pred_target); end
    n_vec++; if (o_cnt_branch !== 32'd0) begin n_bad++; $display("FAIL rmid_cnt_branch: got %0d want 0", o_cnt_branch); end
    n_vec++; if (o_cnt_mispred !== 32'd0) begin n_bad++; $display("FAIL rmid_cnt_mispred: got %0d want 0", o_cnt_mispred); end
    tick();
    @(negedge i_clk) i_rst = 1'b0;
    idle_upd();
    i_pc_if = 32'h54;
    #1;
    n_vec++; if (o_pred_taken !== 1'b0) begin n_bad++; $display("FAIL rmid_upd_lost: got %0b want 0", o_pred_taken); end
    n_vec++; if (o_pred_target !== 32'h58) begin n_bad++; $display("FAIL rmid_upd_target: got %h want 00000058", o_pred_target); end
    n_vec++; if (o_cnt_branch !== 32'd0) begin n_bad++; $display("FAIL rmid_post_cnt: got %0d want 0", o_cnt_branch); end
  endtask

  initial begin
    test_reset();
    test_br_alloc();
    test_br_counter();
    test_jalr();
    test_alias();
    test_no_write();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter DEPTH, default 64, number of predictor entries; SHALL be a power of 2, range 4..1024.
REQ-002 Parameter TAG_WIDTH, default 8, number of PC tag bits stored per entry.
REQ-003 Parameter PC_WIDTH, default 32, width of all PC and target ports.
REQ-004 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_pc_if  in  PC_WIDTH  fetch-stage PC to predict.
REQ-007 o_pred_taken  out  1  prediction that the instruction at i_pc_if redirects.
REQ-008 o_pred_target  out  PC_WIDTH  predicted next PC when o_pred_taken=1; i_pc_if+4 otherwise.
REQ-009 i_upd_valid  in  1  an EX-stage control-flow instruction resolves this cycle.
REQ-010 i_upd_pc  in  PC_WIDTH  PC of the resolving instruction.
REQ-011 i_upd_is_br, i_upd_is_jal, i_upd_is_jalr  in  1 each  instruction class, one-hot when i_upd_valid=1.
REQ-012 i_upd_taken  in  1  actual direction (1 for jal/jalr).
REQ-013 i_upd_target  in  PC_WIDTH  actual target, bit 0 already cleared.
REQ-014 i_upd_pred_taken, i_upd_pred_target  in  1, PC_WIDTH  prediction carried down the pipe with the instruction.
REQ-015 o_mispredict  out  1  pipeline flush request.
REQ-016 o_redirect_pc  out  PC_WIDTH  correct next PC when o_mispredict=1.
REQ-017 o_cnt_branch, o_cnt_mispred  out  32 each  performance counters.

Function
REQ-018 Index SHALL be pc[log2(DEPTH)+1:2]; tag SHALL be the next TAG_WIDTH bits above the index.
REQ-019 Each entry SHALL hold valid, tag, target (PC_WIDTH), type (br/jump), and a 2-bit counter.
REQ-020 Lookup SHALL be combinational, zero-latency: hit = valid && tag match.
REQ-021 o_pred_taken SHALL be hit && (type=jump || counter[1]=1).
REQ-022 o_pred_target SHALL be the entry target when o_pred_taken=1, else i_pc_if+4 (modulo 2^PC_WIDTH).
REQ-023 o_mispredict SHALL be combinational: i_upd_valid && ((i_upd_pred_taken != i_upd_taken) || (i_upd_taken && i_upd_pred_target != i_upd_target)).
REQ-024 o_redirect_pc SHALL be i_upd_target if i_upd_taken, else i_upd_pc+4.
REQ-025 Update hit, br: counter saturating +1 if taken, saturating -1 if not; sequence 00<->01<->10<->11, no wrap past 00 or 11.
REQ-026 Update hit, any class: target field SHALL be overwritten with i_upd_target when i_upd_taken=1.
REQ-027 Update miss, taken: entry SHALL be allocated (overwriting any occupant) with valid=1, new tag, target, type; counter=10 for br, 11 for jal/jalr.
REQ-028 Update miss, br not taken: no table write.
REQ-029 Writes SHALL occur on the rising edge after i_upd_valid=1; lookup in the same cycle to the same index SHALL return the pre-update contents (no bypass).
REQ-030 o_cnt_branch SHALL increment by 1 per cycle with i_upd_valid=1; o_cnt_mispred by 1 per cycle with o_mispredict=1; both wrap from 2^32-1 to 0.
REQ-031 i_upd_valid=0 SHALL cause no state change; upd class/target inputs are don't-care.

Reset
REQ-032 While i_rst=1, all valid bits, counters (to 01), o_cnt_branch, o_cnt_mispred SHALL clear immediately, independent of i_clk.
REQ-033 During and after reset every lookup SHALL miss: o_pred_taken=0, o_pred_target=i_pc_if+4.
REQ-034 Reset asserted in the same cycle as an update SHALL win; no entry written.
REQ-035 Target and tag fields need not be reset.

Verification
REQ-036 Reset, i_pc_if=0x100 -> o_pred_taken=0, o_pred_target=0x104, counters 0.
REQ-037 Update br pc=0x100 taken target 0x80, pred_taken=0 -> o_mispredict=1, o_redirect_pc=0x80; next cycle i_pc_if=0x100 -> pred_taken=1, target 0x80, o_cnt_mispred=1.
REQ-038 Same br then not-taken twice (pred_taken=1, then pred_taken=0) -> first o_mispredict=1 redirect 0x104, counter 10->01->00; lookup 0x100 -> pred_taken=0.
REQ-039 jalr pc=0x200 target 0x300 allocated, later resolves target 0x340 with pred_target 0x300 -> o_mispredict=1, redirect 0x340; subsequent lookup target 0x340.
REQ-040 DEPTH=4: pc 0x10 and 0x20 alias index 0, different tags; second allocation evicts first -> lookup 0x10 misses; simultaneous lookup/update same index returns old data.
REQ-041 Force o_cnt_branch to 0xFFFFFFFF via 2^32-1 updates (or backdoor) then one update -> wraps to 0; assert i_rst mid-sequence -> all lookups miss within same cycle.
